sw_input_ctrl: RTL

- Memory-mapped input peripheral for the 16 board switches; the input-side counterpart of the seven-segment display writer.
- Synchronises and debounces the raw switch levels, then captures rising and falling edges in sticky registers.
- The CPU reads levels and edges, and clears edges, through a dmem-style select, read and write port.
- Sits on the data bus beside dmem, selected by the I/O address decode.

---
 rtl/sw_input_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl: memory-mapped switch input peripheral.
// Two-FF synchroniser, tick-sampled 3-deep debounce, and sticky rise/fall
// edge registers with write-1-to-clear. The CPU reads them through a
// dmem-style cs/rena/wena port.
// Optional feature macro: SWIN_IRQ_EN (adds the addr 3 mask register and a
// registered level irq). When the macro is undefined, irq is tied low.

// One switch bit: synchroniser, debounce sampler, stable level, sticky edges.
module sw_input_lane (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic sw_i,
  input  logic rise_clr_i,
  input  logic fall_clr_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic [2:0] smp_q, smp_d;
  logic       stable_q, stable_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       accept;

  // Next-state: shift on tick, accept three agreeing samples; a set beats a clear.
  always_comb begin
    smp_d    = tick_i ? {smp_q[1:0], sync_q[1]} : smp_q;
    accept   = tick_i && ((smp_d == 3'b111) || (smp_d == 3'b000)) &&
               (smp_d[0] != stable_q);
    stable_d = accept ? smp_d[0] : stable_q;
    rise_d   = (accept &&  smp_d[0]) | (rise_q & ~rise_clr_i);
    fall_d   = (accept && !smp_d[0]) | (fall_q & ~fall_clr_i);
  end

  // State registers; reset discards any partially debounced history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      smp_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], sw_i};
      smp_q    <= smp_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
endmodule

module sw_input_ctrl #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             cs,
  input  logic             rena,
  input  logic             wena,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             wr;
  logic [WIDTH-1:0] stable, rise, fall;
  logic [WIDTH-1:0] rise_clr, fall_clr;
  logic [31:0]      mask_rd;
  logic             unused_wdata;

  assign tick         = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign wr           = cs & wena;
  assign rise_clr     = (wr && addr == 2'd1) ? wdata[WIDTH-1:0] : '0;
  assign fall_clr     = (wr && addr == 2'd2) ? wdata[WIDTH-1:0] : '0;
  assign unused_wdata = ^wdata;

  // Prescaler next count: wrap to zero on the tick cycle.
  always_comb cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  // Prescaler register; free-running, independent of bus activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  sw_input_lane u_lane [WIDTH-1:0] (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick),
    .sw_i      (sw),
    .rise_clr_i(rise_clr),
    .fall_clr_i(fall_clr),
    .stable_o  (stable),
    .rise_o    (rise),
    .fall_o    (fall)
  );

`ifdef SWIN_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  // Mask write and irq level from the currently held edges.
  always_comb begin
    mask_d = (wr && addr == 2'd3) ? wdata[WIDTH-1:0] : mask_q;
    irq_d  = |((rise | fall) & mask_q);
  end

  // Mask and registered irq.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_rd = 32'(mask_q);
  assign irq     = irq_q;
`else
  assign mask_rd = 32'h0;
  assign irq     = 1'b0;
`endif

  // Combinational read mux; zero when not selected, no side effects.
  always_comb begin
    rdata = 32'h0;
    if (cs && rena) begin
      case (addr)
        2'd0:    rdata = 32'(stable);
        2'd1:    rdata = 32'(rise);
        2'd2:    rdata = 32'(fall);
        default: rdata = mask_rd;
      endcase
    end
  end
endmodule
